// File: rtl/traffic_junction_ctrl_pkg.sv
// Shared encodings for the junction controller: FSM states, lamp bit slots, 7-seg glyphs.
package traffic_junction_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_STARTUP,
      ST_CLEAR,
      ST_RED_YEL,
      ST_GREEN,
      ST_GRN_BLINK,
      ST_YELLOW,
      ST_FLASH
   } state_e;

   // One approach's lamp head packed as {red, yel, grn}
   typedef logic [2:0] lamp_t;
   localparam int LMP_RED = 2;
   localparam int LMP_YEL = 1;
   localparam int LMP_GRN = 0;

   // gfedcba, active-high
   localparam logic [6:0] SEG_DASH = 7'b1000000;
   localparam logic [6:0] SEG_DIGIT [10] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
      7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
   };

   function automatic logic blink_state(state_e s);
      return (s == ST_STARTUP) || (s == ST_GRN_BLINK) || (s == ST_FLASH);
   endfunction

endpackage

// File: rtl/traffic_junction_ctrl_if.sv
// Junction controller pin bundle: control/request inputs in, lamp and display outputs out.
interface traffic_junction_ctrl_if #(parameter int NUM_DIR = 2);
   localparam int AW = $clog2(NUM_DIR);

   logic               ena;
   logic               flash_req;
   logic [NUM_DIR-1:0] demand;
   logic [NUM_DIR-1:0] lamp_red;
   logic [NUM_DIR-1:0] lamp_yel;
   logic [NUM_DIR-1:0] lamp_grn;
   logic [AW-1:0]      active_dir;
   logic [3:0]         countdown;
   logic [6:0]         seg;

   modport master (
      input  ena, flash_req, demand,
      output lamp_red, lamp_yel, lamp_grn, active_dir, countdown, seg
   );

   modport slave (
      output ena, flash_req, demand,
      input  lamp_red, lamp_yel, lamp_grn, active_dir, countdown, seg
   );
endinterface

// File: rtl/traffic_junction_ctrl_seg7.sv
// Countdown digit to 7-seg glyph; anything above 9 shows a dash.
module seg7_decoder
   import traffic_junction_ctrl_pkg::*;
(
   input  logic [3:0] val,
   output logic [6:0] seg
);
   always_comb begin
      seg = SEG_DASH;
      if (val < 4'd10) seg = SEG_DIGIT[val];
   end
endmodule

// File: rtl/traffic_junction_ctrl.sv
// Round-robin multi-approach junction controller with all-red clearance,
// optional demand skipping, flash mode, tick prescaler and 7-seg countdown.
module traffic_junction_ctrl
   import traffic_junction_ctrl_pkg::*;
#(
   parameter int NUM_DIR       = 2,
   parameter int TICK_DIV      = 1,
   parameter int T_STARTUP     = 6,
   parameter int T_CLEAR       = 2,
   parameter int T_RED_YELLOW  = 3,
   parameter int T_GREEN       = 9,
   parameter int T_GREEN_BLINK = 5,
   parameter int T_YELLOW      = 3,
   parameter int DEMAND_MODE   = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   traffic_junction_ctrl_if.master bus
);
   localparam int AW = $clog2(NUM_DIR);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   state_e             state, nxt;
   logic [AW-1:0]      active_dir, rr_dir, idx;
   logic [PW-1:0]      presc;
   logic [3:0]         cnt, t_cur, countdown;
   logic [NUM_DIR-1:0] dem_lat;
   logic               blink, first_clr, tick, fin, adv, rr_hit, flash;

   function automatic logic [3:0] phase_len(state_e s);
      case (s)
         ST_STARTUP:   return 4'(T_STARTUP);
         ST_CLEAR:     return 4'(T_CLEAR);
         ST_RED_YEL:   return 4'(T_RED_YELLOW);
         ST_GREEN:     return 4'(T_GREEN);
         ST_GRN_BLINK: return 4'(T_GREEN_BLINK);
         ST_YELLOW:    return 4'(T_YELLOW);
         default:      return 4'd0;
      endcase
   endfunction

   function automatic logic [AW-1:0] inc_dir(logic [AW-1:0] d);
      return (d == AW'(NUM_DIR - 1)) ? '0 : d + 1'b1;
   endfunction

   assign flash     = bus.flash_req;
   assign tick      = (presc == PW'(TICK_DIV - 1));
   assign t_cur     = phase_len(state);
   assign fin       = (cnt == t_cur - 4'd1);
   assign countdown = (state == ST_FLASH) ? 4'd0 : t_cur - cnt;

   // First latched requester after the current owner, wrapping onto itself
   always_comb begin
      rr_dir = inc_dir(active_dir);
      rr_hit = 1'b0;
      idx    = '0;
      if (DEMAND_MODE != 0) begin
         for (int k = 1; k <= NUM_DIR; k++) begin
            idx = AW'((int'(active_dir) + k) % NUM_DIR);
            if (!rr_hit && dem_lat[idx]) begin
               rr_hit = 1'b1;
               rr_dir = idx;
            end
         end
      end
   end

   // Transition request; only acted on when a tick lands
   always_comb begin
      nxt = state;
      adv = 1'b0;
      case (state)
         ST_STARTUP:   begin adv = fin;         nxt = flash ? ST_FLASH : ST_CLEAR;     end
         ST_CLEAR:     begin adv = fin | flash; nxt = flash ? ST_FLASH : ST_RED_YEL;   end
         ST_RED_YEL:   begin adv = fin | flash; nxt = flash ? ST_FLASH : ST_GREEN;     end
         ST_GREEN:     begin adv = fin | flash; nxt = flash ? ST_YELLOW : ST_GRN_BLINK; end
         ST_GRN_BLINK: begin adv = fin | flash; nxt = ST_YELLOW;                       end
         ST_YELLOW:    begin adv = fin;         nxt = flash ? ST_FLASH : ST_CLEAR;     end
         ST_FLASH:     begin adv = !flash;      nxt = ST_CLEAR;                        end
         default:      begin adv = 1'b1;        nxt = ST_STARTUP;                      end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_STARTUP;
         active_dir <= '0;
         presc      <= '0;
         cnt        <= '0;
         blink      <= 1'b0;
         dem_lat    <= '0;
         first_clr  <= 1'b1;
      end else if (bus.ena) begin
         presc   <= tick ? '0 : presc + 1'b1;
         dem_lat <= dem_lat | bus.demand;
         if (tick) begin
            if (adv) begin
               state <= nxt;
               cnt   <= '0;
               blink <= blink_state(state) && blink_state(nxt) && !blink;
               if (state == ST_CLEAR && nxt == ST_RED_YEL) begin
                  first_clr <= 1'b0;
                  if (!first_clr) active_dir <= rr_dir;
               end
               // later NBA on the same bit: clearing beats a same-cycle request
               if (nxt == ST_GREEN) dem_lat[active_dir] <= 1'b0;
            end else begin
               if (state != ST_FLASH) cnt <= cnt + 4'd1;
               blink <= blink_state(state) ? !blink : 1'b0;
            end
         end
      end
   end

   for (genvar i = 0; i < NUM_DIR; i++) begin : g_lane
      lamp_t lamp;
      logic  act;
      assign act = (active_dir == AW'(i));
      always_comb begin
         lamp = '0;
         case (state)
            ST_STARTUP, ST_FLASH: lamp[LMP_YEL] = blink;
            ST_CLEAR:   lamp[LMP_RED] = 1'b1;
            ST_RED_YEL: begin lamp[LMP_RED] = 1'b1; lamp[LMP_YEL] = act; end
            ST_GREEN:     begin lamp[LMP_RED] = !act; lamp[LMP_GRN] = act;         end
            ST_GRN_BLINK: begin lamp[LMP_RED] = !act; lamp[LMP_GRN] = act & blink; end
            ST_YELLOW:    begin lamp[LMP_RED] = !act; lamp[LMP_YEL] = act;         end
            default:    lamp[LMP_RED] = 1'b1;
         endcase
      end
      assign bus.lamp_red[i] = lamp[LMP_RED];
      assign bus.lamp_yel[i] = lamp[LMP_YEL];
      assign bus.lamp_grn[i] = lamp[LMP_GRN];
   end

   assign bus.active_dir = active_dir;
   assign bus.countdown  = countdown;

   seg7_decoder u_seg (
      .val (countdown),
      .seg (bus.seg)
   );

endmodule

// File: tb/tb_traffic_junction_ctrl.sv
// Three controller configurations run side by side against a phase/tick model,
// with directed scenarios followed by a randomised soak.
module tb_traffic_junction_ctrl;

   localparam int P_ST = 0, P_CL = 1, P_RY = 2, P_GR = 3, P_GB = 4, P_YE = 5, P_FL = 6;

   typedef struct {
      int nd, div, dmode, t_st, t_cl, t_ry, t_gr, t_gb, t_ye;
   } cfg_t;

   typedef struct {
      int       ph, el, dir, presc, boff;
      bit       first;
      bit [3:0] dem;
   } mdl_t;

   logic     clk;
   bit [2:0] rstn_v, ena_v, fl_v;
   bit [3:0] dem_v [3];
   cfg_t     cfg [3];
   mdl_t     mdl [3];
   bit       chk_on;
   int       n_cmp, n_bad, cur;

   traffic_junction_ctrl_if #(.NUM_DIR(2)) if0 ();
   traffic_junction_ctrl_if #(.NUM_DIR(4)) if1 ();
   traffic_junction_ctrl_if #(.NUM_DIR(3)) if2 ();

   assign if0.ena = ena_v[0]; assign if0.flash_req = fl_v[0]; assign if0.demand = dem_v[0][1:0];
   assign if1.ena = ena_v[1]; assign if1.flash_req = fl_v[1]; assign if1.demand = dem_v[1];
   assign if2.ena = ena_v[2]; assign if2.flash_req = fl_v[2]; assign if2.demand = dem_v[2][2:0];

   traffic_junction_ctrl #(.NUM_DIR(2)) u0 (.clk(clk), .rst_n(rstn_v[0]), .bus(if0));
   traffic_junction_ctrl #(.NUM_DIR(4), .DEMAND_MODE(1), .T_GREEN(12))
      u1 (.clk(clk), .rst_n(rstn_v[1]), .bus(if1));
   traffic_junction_ctrl #(.NUM_DIR(3), .TICK_DIV(4)) u2 (.clk(clk), .rst_n(rstn_v[2]), .bus(if2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic cfg_t mkcfg(int nd, int div, int dm, int tgr);
      cfg_t c;
      c.nd = nd; c.div = div; c.dmode = dm;
      c.t_st = 6; c.t_cl = 2; c.t_ry = 3; c.t_gr = tgr; c.t_gb = 5; c.t_ye = 3;
      return c;
   endfunction

   function automatic int plen(cfg_t c, int ph);
      case (ph)
         P_ST: return c.t_st;
         P_CL: return c.t_cl;
         P_RY: return c.t_ry;
         P_GR: return c.t_gr;
         P_GB: return c.t_gb;
         P_YE: return c.t_ye;
         default: return 0;
      endcase
   endfunction

   function automatic mdl_t mreset();
      mdl_t m;
      m.ph = P_ST; m.el = 0; m.dir = 0; m.presc = 0; m.boff = 0; m.first = 1'b1; m.dem = '0;
      return m;
   endfunction

   function automatic int pick(mdl_t m, cfg_t c);
      for (int k = 1; k <= c.nd; k++)
         if (c.dmode != 0 && m.dem[(m.dir + k) % c.nd]) return (m.dir + k) % c.nd;
      return (m.dir + 1) % c.nd;
   endfunction

   function automatic mdl_t mstep(mdl_t m, cfg_t c, bit en, bit fl, bit [3:0] din);
      bit last;
      int nx;
      if (!en) return m;
      m.dem = m.dem | din;
      if (m.presc != c.div - 1) begin
         m.presc++;
         return m;
      end
      m.presc = 0;
      last = (m.el == plen(c, m.ph) - 1);
      nx = -1;
      case (m.ph)
         P_ST: if (last) nx = fl ? P_FL : P_CL;
         P_CL: if (fl) nx = P_FL; else if (last) nx = P_RY;
         P_RY: if (fl) nx = P_FL; else if (last) nx = P_GR;
         P_GR: if (fl) nx = P_YE; else if (last) nx = P_GB;
         P_GB: if (fl || last) nx = P_YE;
         P_YE: if (last) nx = fl ? P_FL : P_CL;
         default: if (!fl) nx = P_CL;
      endcase
      if (nx < 0) begin
         m.el++;
         return m;
      end
      if (m.ph == P_CL && nx == P_RY) begin
         if (!m.first) m.dir = pick(m, c);
         m.first = 1'b0;
      end
      if (nx == P_GR) m.dem[m.dir] = 1'b0;
      // flashing carries on from the startup blink phase, otherwise starts dark
      m.boff = (nx == P_FL && m.ph == P_ST) ? c.t_st % 2 : 0;
      m.ph = nx;
      m.el = 0;
      return m;
   endfunction

   function automatic void mexp(mdl_t m, cfg_t c, output bit [3:0] r, output bit [3:0] y,
                                output bit [3:0] g, output int cd);
      bit b, act;
      b = ((m.el + m.boff) % 2) == 1;
      r = '0; y = '0; g = '0;
      for (int i = 0; i < c.nd; i++) begin
         act = (i == m.dir);
         case (m.ph)
            P_ST, P_FL: y[i] = b;
            P_CL: r[i] = 1'b1;
            P_RY: begin r[i] = 1'b1; y[i] = act; end
            P_GR: begin r[i] = !act; g[i] = act; end
            P_GB: begin r[i] = !act; g[i] = act && b; end
            default: begin r[i] = !act; y[i] = act; end
         endcase
      end
      cd = (m.ph == P_FL) ? 0 : plen(c, m.ph) - m.el;
   endfunction

   function automatic bit [6:0] segx(int v);
      case (v)
         0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F; 4: return 7'h66;
         5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07; 8: return 7'h7F; 9: return 7'h6F;
         default: return 7'h40;
      endcase
   endfunction

   always @(posedge clk)
      for (int k = 0; k < 3; k++)
         mdl[k] <= rstn_v[k] ? mstep(mdl[k], cfg[k], ena_v[k], fl_v[k], dem_v[k]) : mreset();

   task automatic cmp(int k, bit [3:0] r, bit [3:0] y, bit [3:0] g, int dir, bit [3:0] cd, bit [6:0] sg);
      bit [3:0] er, ey, eg, msk;
      int ecd;
      mexp(mdl[k], cfg[k], er, ey, eg, ecd);
      n_cmp++;
      if (r != er || y != ey || g != eg || dir != mdl[k].dir || int'(cd) != ecd || sg != segx(ecd)) begin
         n_bad++;
         $display("FAIL model u%0d t=%0t: got r=%b y=%b g=%b dir=%0d cd=%0d seg=%b, need r=%b y=%b g=%b dir=%0d cd=%0d seg=%b",
                  k, $time, r, y, g, dir, cd, sg, er, ey, eg, mdl[k].dir, ecd, segx(ecd));
      end
      msk = 4'((1 << cfg[k].nd) - 1);
      n_cmp++;
      if ($countones(g) > 1 || (g != 0 && ((r | g) & msk) != msk)) begin
         n_bad++;
         $display("FAIL safety u%0d t=%0t: got r=%b g=%b, need one green at most with all others red", k, $time, r, g);
      end
   endtask

   always @(negedge clk)
      if (chk_on) begin
         cmp(0, 4'(if0.lamp_red), 4'(if0.lamp_yel), 4'(if0.lamp_grn), int'(if0.active_dir), if0.countdown, if0.seg);
         cmp(1, if1.lamp_red, if1.lamp_yel, if1.lamp_grn, int'(if1.active_dir), if1.countdown, if1.seg);
         cmp(2, 4'(if2.lamp_red), 4'(if2.lamp_yel), 4'(if2.lamp_grn), int'(if2.active_dir), if2.countdown, if2.seg);
      end

   task automatic chk(string nm, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, need %0d", nm, act, exp);
      end
   endtask

   task automatic at(int p);
      while (cur < p) begin
         @(posedge clk);
         #1;
         cur++;
      end
   endtask

   initial begin
      cfg[0] = mkcfg(2, 1, 0, 9);
      cfg[1] = mkcfg(4, 1, 1, 12);
      cfg[2] = mkcfg(3, 4, 0, 9);
      rstn_v = '0; ena_v = '1; fl_v = '0;
      for (int k = 0; k < 3; k++) dem_v[k] = '0;
      n_cmp = 0; n_bad = 0; chk_on = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("u0 reset countdown", int'(if0.countdown), 6);
      chk("u0 reset lamps", int'({if0.lamp_red, if0.lamp_yel, if0.lamp_grn}), 0);
      chk("u0 reset seg", int'(if0.seg), 'h7D);
      chk("u1 reset countdown", int'(if1.countdown), 6);
      chk("u2 reset dir", int'(if2.active_dir), 0);
      chk_on = 1'b1;
      rstn_v = '1;
      cur = 0;

      at(1);  chk("u0 startup cd", int'(if0.countdown), 5);
              chk("u0 startup yel", int'(if0.lamp_yel), 3);
      at(6);  chk("u0 clear cd", int'(if0.countdown), 2);
              chk("u0 clear red", int'(if0.lamp_red), 3);
      at(11); chk("u0 green grn", int'(if0.lamp_grn), 1);
              chk("u0 green red", int'(if0.lamp_red), 2);
              chk("u0 green cd", int'(if0.countdown), 9);
              chk("u1 green cd", int'(if1.countdown), 12);
              chk("u1 seg dash", int'(if1.seg), 'h40);
      at(14); dem_v[1] = 4'b0100;
      at(15); dem_v[1] = '0;
      at(30); chk("u0 dir1", int'(if0.active_dir), 1);
              chk("u0 dir1 red_yel red", int'(if0.lamp_red), 3);
              chk("u0 dir1 red_yel yel", int'(if0.lamp_yel), 2);
      at(33); chk("u1 skip to dir2", int'(if1.active_dir), 2);
      at(36); chk("u1 dir2 green", int'(if1.lamp_grn), 4);
      at(37); chk("u0 green cnt4 cd", int'(if0.countdown), 5);
              fl_v[0] = 1'b1;
      at(38); chk("u0 flash yellow", int'(if0.lamp_yel), 2);
              chk("u0 flash yellow cd", int'(if0.countdown), 3);
      at(41); chk("u0 flash cd", int'(if0.countdown), 0);
              chk("u0 flash dark", int'(if0.lamp_yel), 0);
      at(42); chk("u0 flash lit", int'(if0.lamp_yel), 3);
      at(44); chk("u2 green grn", int'(if2.lamp_grn), 1);
              chk("u2 green cd", int'(if2.countdown), 9);
      at(45); fl_v[0] = 1'b0;
      at(48); chk("u0 post-flash dir", int'(if0.active_dir), 0);
              chk("u0 post-flash yel", int'(if0.lamp_yel), 1);
              chk("u0 post-flash red", int'(if0.lamp_red), 3);
      at(50); ena_v[2] = 1'b0;
      at(55); chk("u2 frozen cd", int'(if2.countdown), 8);
      at(58); chk("u1 latch cleared dir3", int'(if1.active_dir), 3);
      at(60); ena_v[2] = 1'b1;
      at(61); chk("u0 grn_blink cd", int'(if0.countdown), 4);
      at(62); rstn_v[0] = 1'b0; ena_v[0] = 1'b0;
      at(63); chk("u0 mid reset lamps", int'({if0.lamp_red, if0.lamp_yel, if0.lamp_grn}), 0);
              chk("u0 mid reset cd", int'(if0.countdown), 6);
      at(64); rstn_v[0] = 1'b1; ena_v[0] = 1'b1;
      at(89); chk("u2 last green cd", int'(if2.countdown), 1);
              chk("u2 last green grn", int'(if2.lamp_grn), 1);
      at(90); chk("u2 grn_blink cd", int'(if2.countdown), 5);
              chk("u2 grn_blink grn", int'(if2.lamp_grn), 0);
              chk("u2 grn_blink red", int'(if2.lamp_red), 6);

      repeat (2000) begin
         @(posedge clk);
         #1;
         for (int k = 0; k < 3; k++) begin
            ena_v[k] = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) fl_v[k] = !fl_v[k];
            dem_v[k] = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            rstn_v[k] = ($urandom_range(0, 699) != 0);
         end
      end
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
